prime_checker: RTL and testbench
================================

# prime_checker

Sequential, parametrised primality tester: the successor to our fixed 4/5-bit combinational prime decoders. It accepts an unsigned operand of WIDTH bits on a start/done handshake and decides primality by iterative trial division using only subtract and compare. On composite operands it also reports the smallest factor. It sits behind the switch/keypad input path and drives the LED/seven-segment result logic.

## Interface

- WIDTH, default 8: operand width in bits; legal range 2..16.
- clk  input  1  rising-edge clock; single clock domain.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  request; sampled only in IDLE.
- n  input  WIDTH  operand; captured on the accepted start edge.
- busy  output  1  high in CHECK and REM.
- done  output  1  one-cycle pulse in DONE.
- is_prime  output  1  result; valid from done, held until the next accepted start.
- factor  output  WIDTH  smallest divisor ≥2 if composite; 0 if prime or n<2; held like is_prime.

## Operation

- Registers:
  - n_reg (WIDTH bits): captured operand.
  - d (WIDTH bits): current trial divisor.
  - r (WIDTH bits): running remainder.
  - state: IDLE, CHECK, REM, DONE.
- IDLE: on start=1:
  - n_reg<=n, d<=2.
  - is_prime<=0, factor<=0.
  - go to CHECK.
- IDLE with start=0: stay in IDLE.
- CHECK, in priority order:
  - n_reg<2 → is_prime<=0, go to DONE.
  - d*d > n_reg → is_prime<=1, go to DONE.
  - otherwise r<=n_reg, go to REM.
- d*d is computed at 2*WIDTH bits, so it never overflows. d never exceeds floor(sqrt(n_reg))+1, so d itself never wraps.
- REM, in priority order:
  - r>=d → r<=r-d, stay in REM.
  - r==0 → is_prime<=0, factor<=d, go to DONE.
  - otherwise d<=d+1, go to CHECK.
- DONE: done=1 for exactly this cycle, then go to IDLE unconditionally.
- start while busy or in DONE is ignored; it is not queued.
- start held high continuously: a new operand is accepted on every IDLE cycle, giving back-to-back runs separated by one IDLE cycle.
- Reset (rst_n=0 at any clk edge, including mid-run):
  - state<=IDLE.
  - busy=0, done=0, is_prime=0, factor=0.
  - n_reg, d and r are don't-care.
  - The run in progress is abandoned with no done pulse.

## Timing

- Cycle numbering: cycle 0 is the IDLE cycle in which start=1 is sampled. Cycle 1 is the first CHECK.
- busy and done are decoded directly from state, with no extra register stage.
- Minimum latency: done in cycle 2, for n<2 and for n=2 or 3.
- Latency for general n:
  - Each trial divisor d costs 1 CHECK cycle plus floor(n/d)+1 REM cycles.
  - The final CHECK cycle that passes the d*d>n test is followed by DONE.
  - A run that finds a factor ends one cycle after the REM cycle that sees r==0.
- is_prime and factor change only on the accepted start edge and on the edge that enters DONE. They are stable from the done cycle until the next accepted start.
- No combinational path from any input to any output.

## Test plan

- Reset mid-run: WIDTH=8, start with n=13, drive rst_n=0 in cycle 5 → next cycle busy=0, done=0, is_prime=0, factor=0, and no done pulse follows.
- Trivial and smallest prime: n=0, n=1 and n=2, each started from IDLE → done in cycle 2. n=0 and n=1 give is_prime=0, factor=0; n=2 gives is_prime=1, factor=0.
- Small composites: n=4 → done in cycle 5, is_prime=0, factor=2. n=9 → done in cycle 12, is_prime=0, factor=3.
- Prime with two divisors tried: n=13 → busy in cycles 1–15, done in cycle 16, is_prime=1, factor=0.
- Ignored start and held results: assert start every cycle during the n=13 run → no restart and the result is still 1/0. Results then stay stable with start=0 for 10 cycles.
- Exhaustive sweep: WIDTH=4 over n=0..15, and WIDTH=8 over n=0..255 with start held high.
  - is_prime must match a golden prime list; the WIDTH=4 primes are 2, 3, 5, 7, 11, 13.
  - factor must equal the smallest prime divisor; n=255 gives factor=3.
  - Exactly one done pulse per operand.

Source files
------------

// File: rtl/prime_checker.sv
// Sequential primality tester. It works by trial division using only subtract and compare.
// Each accepted operand is tested against divisors 2, 3, 4, ...
// The run stops when one of these holds:
//   - a divisor leaves a zero remainder (the operand is composite; that divisor is the smallest factor);
//   - d*d exceeds the operand (the operand is prime).
// The results is_prime and factor are registered. They are held from the done pulse
// until the next accepted start.
module prime_checker #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] n,
  output logic             busy,
  output logic             done,
  output logic             is_prime,
  output logic [WIDTH-1:0] factor
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_REM,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             is_prime_q, is_prime_d;
  logic [WIDTH-1:0] factor_q, factor_d;

  // d*d is formed at double width so the square-root bound test never overflows.
  logic [2*WIDTH-1:0] d_sq;
  logic [2*WIDTH-1:0] n_wide;

  assign d_sq   = {{WIDTH{1'b0}}, d_q} * {{WIDTH{1'b0}}, d_q};
  assign n_wide = {{WIDTH{1'b0}}, n_q};

  // Next-state and datapath decisions for the trial-division sequence.
  always_comb begin
    // NOTE: every signal gets a hold value before the case so that no path leaves it unassigned (no latches).
    state_d    = state_q;
    n_d        = n_q;
    d_d        = d_q;
    r_d        = r_q;
    is_prime_d = is_prime_q;
    factor_d   = factor_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d        = n;
          d_d        = WIDTH'(2);
          is_prime_d = 1'b0;
          factor_d   = '0;
          state_d    = S_CHECK;
        end
      end
      S_CHECK: begin
        if (n_q < WIDTH'(2)) begin
          is_prime_d = 1'b0;
          state_d    = S_DONE;
        end else if (d_sq > n_wide) begin
          is_prime_d = 1'b1;
          state_d    = S_DONE;
        end else begin
          r_d     = n_q;
          state_d = S_REM;
        end
      end
      S_REM: begin
        if (r_q >= d_q) begin
          r_d = r_q - d_q;
        end else if (r_q == '0) begin
          is_prime_d = 1'b0;
          factor_d   = d_q;
          state_d    = S_DONE;
        end else begin
          d_d     = d_q + WIDTH'(1);
          state_d = S_CHECK;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state and visible results, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state_q    <= S_IDLE;
      is_prime_q <= 1'b0;
      factor_q   <= '0;
    end else begin
      state_q    <= state_d;
      is_prime_q <= is_prime_d;
      factor_q   <= factor_d;
    end
  end

  // Working registers for the operand, divisor and remainder.
  always_ff @(posedge clk) begin
    // NOTE: these are deliberately left out of reset. IDLE reloads them before any use.
    n_q <= n_d;
    d_q <= d_d;
    r_q <= r_d;
  end

  assign busy     = (state_q == S_CHECK) || (state_q == S_REM);
  assign done     = (state_q == S_DONE);
  assign is_prime = is_prime_q;
  assign factor   = factor_q;

endmodule

// File: tb/tb_prime_checker.sv
// Directed and sweep bench for prime_checker. Two instances are used: WIDTH=8 and WIDTH=4.
// Expected results are pushed to a scoreboard queue whenever an operand is driven.
// They are popped and compared when the matching done pulse appears.
module tb_prime_checker;

  typedef struct {
    logic        ip;
    logic [15:0] f;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] n8 = '0;
  logic       busy8, done8, is_prime8;
  logic [7:0] factor8;

  logic       start4 = 1'b0;
  logic [3:0] n4 = '0;
  logic       busy4, done4, is_prime4;
  logic [3:0] factor4;

  exp_t sb8[$];
  exp_t sb4[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Golden primes below 16: bits 2, 3, 5, 7, 11, 13.
  logic [15:0] primes4 = 16'h28AC;

  prime_checker #(.WIDTH(8)) u_dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start8),
    .n        (n8),
    .busy     (busy8),
    .done     (done8),
    .is_prime (is_prime8),
    .factor   (factor8)
  );

  prime_checker #(.WIDTH(4)) u_dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start4),
    .n        (n4),
    .busy     (busy4),
    .done     (done4),
    .is_prime (is_prime4),
    .factor   (factor4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: modulo-based trial division.
  function automatic exp_t ref_model(input int v);
    exp_t e;
    e.ip = 1'b0;
    e.f  = '0;
    if (v >= 2) begin
      e.ip = 1'b1;
      for (int k = 2; k * k <= v; k++) begin
        if (v % k == 0) begin
          e.ip = 1'b0;
          e.f  = k[15:0];
          break;
        end
      end
    end
    return e;
  endfunction

  task automatic pop_check8(input string tag);
    exp_t e;
    check({tag, "_sb_nonempty"}, 32'(sb8.size() > 0), 1);
    if (sb8.size() > 0) begin
      e = sb8.pop_front();
      check({tag, "_is_prime"}, is_prime8, e.ip);
      check({tag, "_factor"}, factor8, e.f);
    end
  endtask

  task automatic pop_check4(input string tag);
    exp_t e;
    check({tag, "_sb_nonempty"}, 32'(sb4.size() > 0), 1);
    if (sb4.size() > 0) begin
      e = sb4.pop_front();
      check({tag, "_is_prime"}, is_prime4, e.ip);
      check({tag, "_factor"}, factor4, e.f);
    end
  endtask

  // Runs one operand from IDLE on the WIDTH=8 instance.
  // It checks the done cycle number and busy during the run.
  // With hold=1, start stays high and n is changed during the run. Neither may restart the run.
  task automatic run8(input logic [7:0] v, input int exp_lat, input bit hold, input string tag);
    bit got = 1'b0;
    bit busy_ok = 1'b1;
    @(negedge clk);
    start8 = 1'b1;
    n8     = v;
    sb8.push_back(ref_model(int'(v)));
    @(posedge clk);
    #1;
    if (hold) n8 = 8'hFF;
    else      start8 = 1'b0;
    for (int c = 1; c <= 4000; c++) begin
      @(negedge clk);
      if (done8) begin
        start8 = 1'b0;
        check({tag, "_latency"}, c, exp_lat);
        pop_check8(tag);
        got = 1'b1;
        break;
      end else if (!busy8) begin
        busy_ok = 1'b0;
      end
    end
    start8 = 1'b0;
    check({tag, "_done_seen"}, got, 1);
    check({tag, "_busy_during_run"}, busy_ok, 1);
  endtask

  // Sweep on the WIDTH=8 instance with start held high. A new operand is presented after each done.
  task automatic sweep8();
    int k = 0;
    int idle = 0;
    @(negedge clk);
    start8 = 1'b1;
    n8     = 8'd0;
    sb8.push_back(ref_model(0));
    while (k < 256 && idle < 2000) begin
      @(negedge clk);
      if (done8) begin
        pop_check8("sweep8");
        k++;
        idle = 0;
        if (k < 256) begin
          n8 = k[7:0];
          sb8.push_back(ref_model(k));
        end else begin
          start8 = 1'b0;
        end
      end else begin
        idle++;
      end
    end
    start8 = 1'b0;
    check("sweep8_operands_done", k, 256);
    check("sweep8_sb_empty", sb8.size(), 0);
  endtask

  // Sweep on the WIDTH=4 instance. is_prime is checked against the golden list.
  task automatic sweep4();
    int k = 0;
    int idle = 0;
    exp_t e;
    @(negedge clk);
    start4 = 1'b1;
    n4     = 4'd0;
    e = ref_model(0);
    e.ip = primes4[0];
    sb4.push_back(e);
    while (k < 16 && idle < 500) begin
      @(negedge clk);
      if (done4) begin
        pop_check4("sweep4");
        k++;
        idle = 0;
        if (k < 16) begin
          n4 = k[3:0];
          e = ref_model(k);
          e.ip = primes4[k];
          sb4.push_back(e);
        end else begin
          start4 = 1'b0;
        end
      end else begin
        idle++;
      end
    end
    start4 = 1'b0;
    check("sweep4_operands_done", k, 16);
    check("sweep4_sb_empty", sb4.size(), 0);
  endtask

  initial begin
    int dones;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_busy8", busy8, 0);
    check("rst_done8", done8, 0);
    check("rst_is_prime8", is_prime8, 0);
    check("rst_factor8", factor8, 0);
    check("rst_busy4", busy4, 0);
    check("rst_done4", done4, 0);
    rst_n = 1'b1;

    // Trivial operands and the smallest primes.
    run8(8'd0, 2, 1'b0, "n0");
    run8(8'd1, 2, 1'b0, "n1");
    run8(8'd2, 2, 1'b0, "n2");
    run8(8'd3, 2, 1'b0, "n3");

    // Small composites.
    run8(8'd4, 5, 1'b0, "n4");
    run8(8'd9, 12, 1'b0, "n9");

    // Prime with start held high and n disturbed during the run.
    run8(8'd13, 16, 1'b1, "n13_hold");

    // Results must stay stable with start low.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("hold_is_prime", is_prime8, 1);
      check("hold_factor", factor8, 0);
      check("hold_no_done", done8, 0);
    end

    // Reset in cycle 5 of a run on n=13.
    @(negedge clk);
    start8 = 1'b1;
    n8     = 8'd13;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy8, 0);
    check("midrst_done", done8, 0);
    check("midrst_is_prime", is_prime8, 0);
    check("midrst_factor", factor8, 0);
    rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done8) dones++;
    end
    check("midrst_no_done_after", dones, 0);
    check("midrst_idle_after", busy8, 0);

    // Exhaustive sweeps.
    sweep4();
    sweep8();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
